// File: rtl/rep_umul_pkg.sv
// Shared types and helpers for the run-controlled unary multiplier array.
package rep_umul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_BITWIDTH = 8;
    localparam int unsigned DEF_CH       = 4;
    localparam int unsigned DEF_WINDOW   = 1 << DEF_BITWIDTH;

    // Number of enabled cycles in one run window.
    function automatic int unsigned window_len(input int unsigned bw);
        return 1 << bw;
    endfunction

    // LSB position of a lane inside a flattened lane bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned bw);
        return lane * bw;
    endfunction

endpackage

// File: rtl/rep_umul_lane.sv
// One multiplier lane: operand buffer, stochastic compare/product, window accumulator.
module rep_umul_lane
    import rep_umul_pkg::*;
#(
    parameter int unsigned BITWIDTH = DEF_BITWIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_b,
    input  logic [BITWIDTH-1:0] b_in,
    input  logic                a_in,
    input  logic [BITWIDTH-1:0] seq,
    input  logic                bipolar,
    input  logic                clr_acc,
    input  logic                sample,
    input  logic                capture,
    output logic                raw_c,
    output logic [BITWIDTH-1:0] result
);

    logic [BITWIDTH-1:0] b_q, b_d;
    logic [BITWIDTH-1:0] acc_q, acc_d;
    logic [BITWIDTH-1:0] result_q, result_d;
    logic                gt;

    always_comb begin
        gt    = b_q > seq;
        raw_c = bipolar ? ~(a_in ^ gt) : (a_in & gt);
        b_d   = load_b ? b_in : b_q;
        acc_d = acc_q;
        if (clr_acc) begin
            acc_d = '0;
        end else if (sample) begin
            acc_d = acc_q + BITWIDTH'(raw_c);
        end
        // The final edge captures the sum including the last sample.
        result_d = capture ? acc_d : result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/sobolrng.sv
// First-dimension Sobol sequence generator in Gray-code order: each enabled
// step flips the direction bit picked by the lowest zero bit of the index.
module sobolrng #(
    parameter int unsigned BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    output logic [BITWIDTH-1:0] sobolSeq
);

    logic [BITWIDTH-1:0] idx_q, idx_d;
    logic [BITWIDTH-1:0] seq_q, seq_d;
    logic [BITWIDTH-1:0] flip;
    logic                found;

    always_comb begin
        flip  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < BITWIDTH; i++) begin
            if (!found && !idx_q[i]) begin
                flip[BITWIDTH-1-i] = 1'b1;
                found              = 1'b1;
            end
        end
        idx_d = idx_q;
        seq_d = seq_q;
        if (iClr) begin
            idx_d = '0;
            seq_d = '0;
        end else if (iEn) begin
            idx_d = idx_q + BITWIDTH'(1);
            seq_d = seq_q ^ flip;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            idx_q <= '0;
            seq_q <= '0;
        end else begin
            idx_q <= idx_d;
            seq_q <= seq_d;
        end
    end

    assign sobolSeq = seq_q;

endmodule

// File: rtl/rep_umul_array.sv
// Multi-lane run-controlled unary multiplier sharing one Sobol generator.
// Optional XNOR bipolar mode enabled by defining REP_UMUL_BIPOLAR_EN.
module rep_umul_array
    import rep_umul_pkg::*;
#(
    parameter int unsigned BITWIDTH = DEF_BITWIDTH,
    parameter int unsigned CH       = DEF_CH
) (
    input  logic                   iClk,
    input  logic                   iRstN,
    input  logic                   iStart,
    input  logic                   iEn,
    input  logic                   loadB,
    input  logic [CH*BITWIDTH-1:0] iB,
    input  logic [CH-1:0]          iA,
`ifdef REP_UMUL_BIPOLAR_EN
    input  logic                   iBipolar,
`endif
    output logic [CH-1:0]          oBit,
    output logic [CH*BITWIDTH-1:0] oResult,
    output logic                   oBusy,
    output logic                   oDone
);

    localparam int unsigned WINDOW = window_len(BITWIDTH);

    state_e              state_q, state_d;
    logic [BITWIDTH-1:0] cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                clr_c, sample_c, capture_c, load_c;
    logic                bipolar;
    logic [BITWIDTH-1:0] seq;
    logic [CH-1:0]       raw_c;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_c     = 1'b0;
        sample_c  = 1'b0;
        capture_c = 1'b0;
        load_c    = loadB && (state_q != ST_RUN);
        unique case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    clr_c   = 1'b1;
                end
            end
            ST_RUN: begin
                if (iEn) begin
                    sample_c = 1'b1;
                    cnt_d    = cnt_q + BITWIDTH'(1);
                    if (cnt_q == BITWIDTH'(WINDOW - 1)) begin
                        state_d   = ST_DONE;
                        capture_c = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef REP_UMUL_BIPOLAR_EN
    logic bipolar_q, bipolar_d;

    // Mode is latched at the start edge and frozen for the run.
    always_comb begin
        bipolar_d = clr_c ? iBipolar : bipolar_q;
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            bipolar_q <= 1'b0;
        end else begin
            bipolar_q <= bipolar_d;
        end
    end

    assign bipolar = bipolar_q;
`else
    assign bipolar = 1'b0;
`endif

    sobolrng #(
        .BITWIDTH (BITWIDTH)
    ) u_rng (
        .iClk     (iClk),
        .iRstN    (iRstN),
        .iEn      (sample_c),
        .iClr     (clr_c),
        .sobolSeq (seq)
    );

    for (genvar c = 0; c < CH; c++) begin : g_lane
        rep_umul_lane #(
            .BITWIDTH (BITWIDTH)
        ) u_lane (
            .clk     (iClk),
            .rst_n   (iRstN),
            .load_b  (load_c),
            .b_in    (iB[lane_lsb(c, BITWIDTH) +: BITWIDTH]),
            .a_in    (iA[c]),
            .seq     (seq),
            .bipolar (bipolar),
            .clr_acc (clr_c),
            .sample  (sample_c),
            .capture (capture_c),
            .raw_c   (raw_c[c]),
            .result  (oResult[lane_lsb(c, BITWIDTH) +: BITWIDTH])
        );
    end

    assign oBit  = raw_c & {CH{busy_q & iEn}};
    assign oBusy = busy_q;
    assign oDone = done_q;

endmodule

// File: tb/tb_rep_umul_array.sv
// Self-checking bench for rep_umul_array (BITWIDTH=8, CH=2) against a Sobol reference model.
module tb_rep_umul_array;

    localparam int unsigned BW  = 8;
    localparam int unsigned NCH = 2;
    localparam int          WIN = 256;

    logic             iClk = 1'b0;
    logic             iRstN;
    logic             iStart;
    logic             iEn;
    logic             loadB;
    logic [NCH*BW-1:0] iB;
    logic [NCH-1:0]   iA;
    logic             iBipolar;
    logic [NCH-1:0]   oBit;
    logic [NCH*BW-1:0] oResult;
    logic             oBusy;
    logic             oDone;

    int n_cmp = 0;
    int n_err = 0;

    rep_umul_array #(
        .BITWIDTH (BW),
        .CH       (NCH)
    ) dut (
        .iClk    (iClk),
        .iRstN   (iRstN),
        .iStart  (iStart),
        .iEn     (iEn),
        .loadB   (loadB),
        .iB      (iB),
        .iA      (iA),
`ifdef REP_UMUL_BIPOLAR_EN
        .iBipolar(iBipolar),
`endif
        .oBit    (oBit),
        .oResult (oResult),
        .oBusy   (oBusy),
        .oDone   (oDone)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // k-th Sobol point: bit-reversed Gray code of k.
    function automatic logic [7:0] sob(input int k);
        logic [7:0] g;
        logic [7:0] r;
        g = 8'(k ^ (k >> 1));
        for (int i = 0; i < 8; i++) r[i] = g[7-i];
        return r;
    endfunction

    // amode: 0 ones, 1 random, 2 lane0=0/lane1=1, 3 zeros
    // enmode: 0 always, 1 toggle (low first), 2 random
    task automatic run(input logic [7:0] b0, input logic [7:0] b1, input int amode,
                       input int enmode, input bit bip, input bit load_mid, input int rst_at);
        int         k;
        int         cyc;
        int         acc [NCH];
        logic [7:0] bb [NCH];
        logic [NCH-1:0] a;
        logic [NCH-1:0] expb;
        logic [NCH-1:0] rbit;
        logic       en;
        logic       gt;
        logic [7:0] s;
        logic [NCH*BW-1:0] prev_res;
        prev_res = oResult;
        @(negedge iClk);
        iB = {b1, b0};
        loadB = 1'b1;
        iStart = 1'b1;
        iBipolar = bip;
        @(posedge iClk);
        #1;
        loadB = 1'b0;
        iStart = 1'b0;
        bb[0] = b0;
        bb[1] = b1;
        acc[0] = 0;
        acc[1] = 0;
        k = 0;
        cyc = 0;
        while (k < WIN && cyc < 2000) begin
            @(negedge iClk);
            if (rst_at == cyc) begin
                iRstN = 1'b0;
                #1;
                check("abort_busy", 32'(oBusy), 32'd0);
                check("abort_result", 32'(oResult), 32'd0);
                check("abort_done", 32'(oDone), 32'd0);
                @(negedge iClk);
                iRstN = 1'b1;
                repeat (4) begin
                    @(posedge iClk);
                    #1;
                    check("abort_nodone", 32'(oDone), 32'd0);
                end
                return;
            end
            case (enmode)
                0: en = 1'b1;
                1: en = (cyc % 2) == 1;
                default: en = ($urandom % 4) != 0;
            endcase
            case (amode)
                0: a = '1;
                1: a = NCH'($urandom);
                2: a = 2'b10;
                default: a = '0;
            endcase
            iEn = en;
            iA = a;
            if (load_mid) begin
                loadB = 1'b1;
                iB = {8'd200, 8'd200};
            end
            #1;
            s = sob(k);
            for (int c = 0; c < NCH; c++) begin
                gt = bb[c] > s;
                rbit[c] = bip ? ~(a[c] ^ gt) : (a[c] & gt);
                expb[c] = rbit[c] & en;
            end
            check("obit", 32'(oBit), 32'(expb));
            check("busy_run", 32'(oBusy), 32'd1);
            if (cyc == 0) check("result_hold", 32'(oResult), 32'(prev_res));
            @(posedge iClk);
            if (en) begin
                for (int c = 0; c < NCH; c++) acc[c] += int'(rbit[c]);
                k++;
            end
            cyc++;
        end
        #1;
        loadB = 1'b0;
        check("window_len", 32'(k), 32'(WIN));
        if (enmode == 0) check("cycles_always", 32'(cyc), 32'd256);
        if (enmode == 1) check("cycles_toggle", 32'(cyc), 32'd512);
        check("done_pulse", 32'(oDone), 32'd1);
        check("busy_done", 32'(oBusy), 32'd0);
        check("result_l0", 32'(oResult[7:0]), 32'(acc[0]));
        check("result_l1", 32'(oResult[15:8]), 32'(acc[1]));
        @(posedge iClk);
        #1;
        check("done_once", 32'(oDone), 32'd0);
        check("idle_busy", 32'(oBusy), 32'd0);
    endtask

    initial begin
        iRstN = 1'b0;
        iStart = 1'b0;
        iEn = 1'b0;
        loadB = 1'b0;
        iB = '0;
        iA = '0;
        iBipolar = 1'b0;
        #12;
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        check("rst_result", 32'(oResult), 32'd0);
        check("rst_obit", 32'(oBit), 32'd0);
        @(negedge iClk);
        iRstN = 1'b1;

        run(8'd128, 8'd0, 0, 0, 1'b0, 1'b0, -1);
        check("exact_128", 32'(oResult), 32'h0000_0080);
        run(8'd255, 8'd1, 0, 1, 1'b0, 1'b0, -1);
        check("exact_255_1", 32'(oResult), 32'h0000_01FF);
        run(8'd100, 8'd100, 0, 0, 1'b0, 1'b1, -1);
        check("frozen_b", 32'(oResult), 32'h0000_6464);
        run(8'd200, 8'd200, 0, 2, 1'b0, 1'b0, -1);
        check("reload_b", 32'(oResult), 32'h0000_C8C8);
        run(8'd90, 8'd33, 1, 0, 1'b0, 1'b0, 50);
        run(8'd50, 8'd170, 1, 2, 1'b0, 1'b0, -1);
        run(8'd77, 8'd77, 2, 0, 1'b0, 1'b0, -1);
        check("lane0_zero", 32'(oResult), 32'h0000_4D00);
        for (int r = 0; r < 3; r++) begin
            run(8'($urandom), 8'($urandom), 1, 2, 1'b0, 1'b0, -1);
        end
`ifdef REP_UMUL_BIPOLAR_EN
        run(8'd64, 8'd64, 3, 0, 1'b1, 1'b0, -1);
        check("bipolar_zeros", 32'(oResult), 32'h0000_C0C0);
        run(8'd128, 8'd128, 0, 0, 1'b1, 1'b0, -1);
        check("bipolar_ones", 32'(oResult), 32'h0000_8080);
        run(8'($urandom), 8'($urandom), 1, 2, 1'b1, 1'b0, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
